// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the serial subtractor sequencer:
//   - state_e      : sequencer FSM states
//   - SERIAL_SUB_N : default operand / result width
//   - cnt_width()  : bit-counter width for an N-bit operation (counts 0..N)
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    localparam int SERIAL_SUB_N = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_sub_piso.sv
// -----------------------------------------------------------------------------
// serial_sub_piso
// N-bit parallel-load, right-shift, zero-fill register. The LSB is presented
// directly on ser_o so the serial output is a plain flop output.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_b  in   asynchronous active-low reset (clears the register)
//   load_i   in   load par_i (has priority over shift_i)
//   shift_i  in   shift right by one, zero into the MSB
//   par_i    in   N-bit parallel load value
//   ser_o    out  current LSB
// -----------------------------------------------------------------------------
module serial_sub_piso #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset_b,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [N-1:0] par_i,
    output logic         ser_o
);

    logic [N-1:0] data_q;
    logic [N-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = par_i;
        end else if (shift_i) begin
            data_d = {1'b0, data_q[N-1:1]};
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_o = data_q[0];

endmodule

// File: rtl/serial_sub_sequencer.sv
// -----------------------------------------------------------------------------
// serial_sub_sequencer
// Control and data staging in front of a bit-serial subtractor. Accepts two
// N-bit unsigned operands on a ready/start handshake, streams them LSB-first
// on SI_A/SI_B while shift_control is high for exactly N clocks, collects the
// returned SO bits into a difference register and pulses done.
//
// Optional feature (macro SERIAL_SUB_SIGNMAG_EN):
//   defined     : a local borrow tracker drives negative (A<B) and
//                 magnitude (|A-B|).
//   not defined : no borrow tracker; negative and magnitude are tied to 0.
//
// Ports:
//   clock          in   rising-edge clock shared with the subtractor
//   reset_b        in   asynchronous active-low reset
//   start          in   request, accepted on an edge where ready=1
//   A_in, B_in     in   minuend / subtrahend, sampled on the accepting edge
//   SO             in   serial difference bit from the subtractor
//   SI_A, SI_B     out  current minuend / subtrahend bit
//   shift_control  out  subtractor carry flop enable
//   sub_clr_b      out  one-cycle active-low preset of the subtractor carry
//   ready          out  idle, start can be accepted
//   done           out  one-cycle completion pulse
//   diff           out  (A-B) mod 2^N, held until the next result
//   negative       out  A<B
//   magnitude      out  |A-B|
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready high, waiting for start
// CLEAR | sub_clr_b low for one cycle, presets the subtractor carry
// SHIFT | shift_control high, one bit per edge for N edges
// DONE  | done pulse, result registers valid
// -----------------------------------------------------------------------------
module serial_sub_sequencer
    import serial_sub_pkg::*;
#(
    parameter int N = SERIAL_SUB_N
) (
    input  logic         clock,
    input  logic         reset_b,
    input  logic         start,
    input  logic [N-1:0] A_in,
    input  logic [N-1:0] B_in,
    input  logic         SO,
    output logic         SI_A,
    output logic         SI_B,
    output logic         shift_control,
    output logic         sub_clr_b,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         negative,
    output logic [N-1:0] magnitude
);

    localparam int CNT_W = cnt_width(N);

    state_e state_q;
    state_e state_d;

    logic ready_q,   ready_d;
    logic done_q,    done_d;
    logic shift_q,   shift_d;
    logic clr_b_q,   clr_b_d;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [N-1:0]     diff_sr_q;
    logic [N-1:0]     diff_sr_d;
    logic [N-1:0]     diff_q;
    logic [N-1:0]     diff_d;

    logic accept;
    logic shift_en;
    logic last_shift;

    assign accept     = (state_q == ST_IDLE) && start;
    assign shift_en   = (state_q == ST_SHIFT);
    assign last_shift = shift_en && (cnt_q == CNT_W'(N - 1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            shift_q <= 1'b0;
            clr_b_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            shift_q <= shift_d;
            clr_b_q <= clr_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)      state_d = ST_CLEAR;
            ST_CLEAR:                 state_d = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one
    // is a clean flop output aligned with the state it belongs to.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
        shift_d = (state_d == ST_SHIFT);
        clr_b_d = (state_d != ST_CLEAR);
    end

    assign ready         = ready_q;
    assign done          = done_q;
    assign shift_control = shift_q;
    assign sub_clr_b     = clr_b_q;

    // ------------------------------------------------------ operand staging
    serial_sub_piso #(.N(N)) u_piso_a (
        .clock   (clock),
        .reset_b (reset_b),
        .load_i  (accept),
        .shift_i (shift_en),
        .par_i   (A_in),
        .ser_o   (SI_A)
    );

    serial_sub_piso #(.N(N)) u_piso_b (
        .clock   (clock),
        .reset_b (reset_b),
        .load_i  (accept),
        .shift_i (shift_en),
        .par_i   (B_in),
        .ser_o   (SI_B)
    );

    // ------------------------------------------------ result collection
    always_comb begin
        cnt_d     = cnt_q;
        diff_sr_d = diff_sr_q;
        diff_d    = diff_q;
        if (accept) begin
            cnt_d     = '0;
            diff_sr_d = '0;
        end else if (shift_en) begin
            cnt_d     = cnt_q + CNT_W'(1);
            diff_sr_d = {SO, diff_sr_q[N-1:1]};
            // The last SO bit goes straight into diff so the result is
            // complete on the same edge that leaves SHIFT.
            if (last_shift) begin
                diff_d = {SO, diff_sr_q[N-1:1]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            cnt_q     <= '0;
            diff_sr_q <= '0;
            diff_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            diff_sr_q <= diff_sr_d;
            diff_q    <= diff_d;
        end
    end

    assign diff = diff_q;

`ifdef SERIAL_SUB_SIGNMAG_EN
    // ------------------------------------------------ borrow tracker
    // Mirrors the subtractor's carry chain as a borrow (borrow = ~carry),
    // starting from no borrow to match the carry preset during CLEAR.
    logic         borrow_q, borrow_d;
    logic         borrow_nxt;
    logic         neg_q,    neg_d;
    logic [N-1:0] mag_q,    mag_d;

    assign borrow_nxt = (~SI_A & SI_B) | (~(SI_A ^ SI_B) & borrow_q);

    always_comb begin
        borrow_d = borrow_q;
        neg_d    = neg_q;
        mag_d    = mag_q;
        if (accept) begin
            borrow_d = 1'b0;
        end else if (shift_en) begin
            borrow_d = borrow_nxt;
            if (last_shift) begin
                neg_d = borrow_nxt;
                mag_d = borrow_nxt ? (~diff_sr_d + N'(1)) : diff_sr_d;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            borrow_q <= 1'b0;
            neg_q    <= 1'b0;
            mag_q    <= '0;
        end else begin
            borrow_q <= borrow_d;
            neg_q    <= neg_d;
            mag_q    <= mag_d;
        end
    end

    assign negative  = neg_q;
    assign magnitude = mag_q;
`else
    assign negative  = 1'b0;
    assign magnitude = '0;
`endif

endmodule
